// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and helpers for the VGA timing generator.
//   - Default 640x480@60 timing (pixels / lines), default coordinate width.
//   - Helpers to derive axis totals and sync window bounds.
//   - sync_bus_t: the bundle of signals that travels through the sync delay line.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int COORD_W_DEF  = 12;

  // Total slots (or lines) along one axis.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First position of the sync pulse (inclusive).
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First position after the sync pulse (exclusive bound).
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Signals that are delayed together to line up with renderer latency.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_bus_t;

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One axis (horizontal or vertical) of the VGA raster: a wrapping position
// counter plus combinational decode of the current position.
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous active-high reset (count -> 0)
//   i_en      advance by one position this cycle
//   o_count   current position, 0..TOTAL-1
//   o_wrap    current position is the last one (next advance returns to 0)
//   o_active  current position is inside the visible region
//   o_sync    sync level for the current position (POL when asserted)
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter bit POL    = 1'b0,
  parameter int W      = COORD_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_active,
  output logic         o_sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(sync_start(ACTIVE, FP));
  localparam logic [W-1:0] SYNC_HI = W'(sync_end(ACTIVE, FP, SYNC));

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         in_sync;

  always_comb begin
    count_d = count_q;
    if (i_en) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign in_sync  = (count_q >= SYNC_LO) && (count_q < SYNC_HI);
  assign o_count  = count_q;
  assign o_wrap   = (count_q == LAST);
  assign o_active = (count_q < ACT_END);
  assign o_sync   = in_sync ? POL : !POL;

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Parametrised VGA raster timing generator running entirely in the i_clk
// domain. A prescaler produces a one-cycle pixel-slot strobe; horizontal and
// vertical axis counters advance on that strobe. All outputs are registered
// and load the decode of the current (h,v) on the strobe edge, so they show
// position p during the slot that follows the edge.
// Ports:
//   i_clk           system clock
//   i_rst           asynchronous active-high reset
//   o_pix_ce        pixel-slot strobe (one i_clk cycle per CLK_DIV cycles)
//   o_hsync/o_vsync sync outputs, delayed by SYNC_DELAY slots
//   o_blank         1 outside the visible area, delayed by SYNC_DELAY slots
//   o_active        1 inside the visible area (undelayed)
//   o_x/o_y         raw raster position including blanking (undelayed)
//   o_line_start    one-cycle pulse when o_x loads 0
//   o_frame_start   one-cycle pulse when (o_x,o_y) loads (0,0)
//   o_vblank_start  one-cycle pulse when (o_x,o_y) loads (0,V_ACTIVE)
// -----------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 0,
  parameter int COORD_W    = COORD_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_pix_ce,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_blank,
  output logic               o_active,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic               o_vblank_start
);

  // CLK_DIV is limited to 1..16, so the prescaler fits in 4 bits.
  localparam logic [3:0]         DIV_LAST    = 4'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] VBLANK_ROW  = COORD_W'(V_ACTIVE);
  localparam sync_bus_t          SYNC_IDLE   = '{hsync: !H_SYNC_POL,
                                                 vsync: !V_SYNC_POL,
                                                 blank: 1'b1};

  // ---------------------------------------------------------------------------
  // Prescaler. ce_q is registered alongside div_q so that it equals
  // (div_q == CLK_DIV-1) in normal operation but is held low during reset,
  // which matters for CLK_DIV=1 where the compare would otherwise be true.
  // ---------------------------------------------------------------------------
  logic [3:0] div_q;
  logic [3:0] div_d;
  logic       ce_q;
  logic       ce_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    ce_d  = (div_d == DIV_LAST);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q <= 4'd0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ce_q  <= ce_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Axis counters. The vertical counter steps on the same strobe edge as the
  // horizontal wrap, so vsync edges line up with h=0.
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  logic               h_wrap;
  logic               v_wrap;
  logic               h_active;
  logic               v_active;
  logic               h_sync;
  logic               v_sync;
  logic               v_en;

  assign v_en = ce_q && h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_SYNC_POL),
    .W      (COORD_W)
  ) u_h_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (ce_q),
    .o_count  (h_count),
    .o_wrap   (h_wrap),
    .o_active (h_active),
    .o_sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_SYNC_POL),
    .W      (COORD_W)
  ) u_v_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (v_en),
    .o_count  (v_count),
    .o_wrap   (v_wrap),
    .o_active (v_active),
    .o_sync   (v_sync)
  );

  // ---------------------------------------------------------------------------
  // Origin flags: line_origin_q is 1 exactly when h_count==0 and
  // frame_origin_q exactly when (h_count,v_count)==(0,0). They are derived
  // from the wrap flags at the advancing edge, which replaces wide zero
  // compares with one flop each. Both start at 1 because reset parks the
  // counters at the origin.
  // ---------------------------------------------------------------------------
  logic line_origin_q;
  logic frame_origin_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      line_origin_q  <= 1'b1;
      frame_origin_q <= 1'b1;
    end else if (ce_q) begin
      line_origin_q  <= h_wrap;
      frame_origin_q <= h_wrap && v_wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Undelayed output registers. Strobes default low every cycle and are only
  // raised on a strobe edge, so they are one i_clk cycle wide for any divide.
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               active_q;
  logic               line_start_q;
  logic               frame_start_q;
  logic               vblank_start_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q            <= '0;
      y_q            <= '0;
      active_q       <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      if (ce_q) begin
        x_q            <= h_count;
        y_q            <= v_count;
        active_q       <= h_active && v_active;
        line_start_q   <= line_origin_q;
        frame_start_q  <= frame_origin_q;
        vblank_start_q <= line_origin_q && (v_count == VBLANK_ROW);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sync delay line. Stage 0 is the output register aligned with o_x; each of
  // the SYNC_DELAY further stages adds one pixel slot. Reset fills every stage
  // with the idle (deasserted, blanked) pattern.
  // ---------------------------------------------------------------------------
  sync_bus_t sync_raw;
  sync_bus_t stage_q [0:SYNC_DELAY];

  assign sync_raw = '{hsync: h_sync, vsync: v_sync, blank: !(h_active && v_active)};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stage_q[0] <= SYNC_IDLE;
    end else if (ce_q) begin
      stage_q[0] <= sync_raw;
    end
  end

  for (genvar gi = 1; gi <= SYNC_DELAY; gi++) begin : g_delay
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        stage_q[gi] <= SYNC_IDLE;
      end else if (ce_q) begin
        stage_q[gi] <= stage_q[gi-1];
      end
    end
  end

  assign o_pix_ce       = ce_q;
  assign o_hsync        = stage_q[SYNC_DELAY].hsync;
  assign o_vsync        = stage_q[SYNC_DELAY].vsync;
  assign o_blank        = stage_q[SYNC_DELAY].blank;
  assign o_active       = active_q;
  assign o_x            = x_q;
  assign o_y            = y_q;
  assign o_line_start   = line_start_q;
  assign o_frame_start  = frame_start_q;
  assign o_vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Directed bench for vga_timing. Four instances share one clock, each with its
// own reset:
//   u_def   : default 640x480 timing, CLK_DIV=2
//   u_dly   : default timing with SYNC_DELAY=3
//   u_tall  : default vertical timing, 16-slot lines, CLK_DIV=1
//   u_small : 8x5 raster, CLK_DIV=1, positive sync polarity
// -----------------------------------------------------------------------------
module tb_vga_timing;

  logic clk;
  logic rst_d, rst_y, rst_t, rst_s;

  int n_cmp = 0;
  int n_bad = 0;

  // u_def
  logic d_pix_ce, d_hsync, d_vsync, d_blank, d_active, d_ls, d_fs, d_vb;
  logic [11:0] d_x, d_y;
  // u_dly
  logic y_pix_ce, y_hsync, y_vsync, y_blank, y_active, y_ls, y_fs, y_vb;
  logic [11:0] y_x, y_y;
  // u_tall
  logic t_pix_ce, t_hsync, t_vsync, t_blank, t_active, t_ls, t_fs, t_vb;
  logic [11:0] t_x, t_y;
  // u_small
  logic s_pix_ce, s_hsync, s_vsync, s_blank, s_active, s_ls, s_fs, s_vb;
  logic [11:0] s_x, s_y;

  vga_timing u_def (
    .i_clk(clk), .i_rst(rst_d), .o_pix_ce(d_pix_ce), .o_hsync(d_hsync),
    .o_vsync(d_vsync), .o_blank(d_blank), .o_active(d_active), .o_x(d_x),
    .o_y(d_y), .o_line_start(d_ls), .o_frame_start(d_fs), .o_vblank_start(d_vb)
  );

  vga_timing #(.SYNC_DELAY(3)) u_dly (
    .i_clk(clk), .i_rst(rst_y), .o_pix_ce(y_pix_ce), .o_hsync(y_hsync),
    .o_vsync(y_vsync), .o_blank(y_blank), .o_active(y_active), .o_x(y_x),
    .o_y(y_y), .o_line_start(y_ls), .o_frame_start(y_fs), .o_vblank_start(y_vb)
  );

  vga_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .CLK_DIV(1)) u_tall (
    .i_clk(clk), .i_rst(rst_t), .o_pix_ce(t_pix_ce), .o_hsync(t_hsync),
    .o_vsync(t_vsync), .o_blank(t_blank), .o_active(t_active), .o_x(t_x),
    .o_y(t_y), .o_line_start(t_ls), .o_frame_start(t_fs), .o_vblank_start(t_vb)
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(1)
  ) u_small (
    .i_clk(clk), .i_rst(rst_s), .o_pix_ce(s_pix_ce), .o_hsync(s_hsync),
    .o_vsync(s_vsync), .o_blank(s_blank), .o_active(s_active), .o_x(s_x),
    .o_y(s_y), .o_line_start(s_ls), .o_frame_start(s_fs), .o_vblank_start(s_vb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  ce_cnt, hs_cnt, hs_fall_x, hs_rise_x;
    int  dh_fall_x, db_clear_x, db_rise_x, da_fall_x;
    int  vs_cnt, vs_bad, vb_cnt, vb_x, vb_y, blank_bad, act_bad, max_y;
    int  hs_hi, vs_hi, ls_cnt;
    bit  done, prev_hs, prev_dh, prev_db, prev_da;

    rst_d = 1'b1; rst_y = 1'b1; rst_t = 1'b1; rst_s = 1'b1;

    // ---------------- Test 1: reset values and first slot ----------------
    repeat (5) tick();
    chk("rst_hsync", d_hsync, 1);
    chk("rst_vsync", d_vsync, 1);
    chk("rst_blank", d_blank, 1);
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_active", d_active, 0);
    chk("rst_pix_ce", d_pix_ce, 0);
    chk("rst_strobes", {d_ls, d_fs, d_vb}, 0);
    chk("rst_dly_blank", y_blank, 1);
    chk("rst_small_hsync", s_hsync, 0);
    chk("rst_small_pix_ce", s_pix_ce, 0);

    rst_d = 1'b0; rst_y = 1'b0;
    #1;
    chk("rel_cycle1_ce", d_pix_ce, 0);
    tick();
    chk("rel_cycle2_ce", d_pix_ce, 1);
    chk("rel_cycle2_active", d_active, 0);
    tick();
    chk("first_x", d_x, 0);
    chk("first_y", d_y, 0);
    chk("first_active", d_active, 1);
    chk("first_line_start", d_ls, 1);
    chk("first_frame_start", d_fs, 1);
    chk("first_blank", d_blank, 0);
    chk("first_ce_low", d_pix_ce, 0);
    chk("first_dly_blank_fill", y_blank, 1);
    chk("first_dly_active", y_active, 1);
    tick();
    chk("strobe_width_ls", d_ls, 0);
    chk("strobe_width_fs", d_fs, 0);

    // ---------------- Test 2 + 4: one full default line ----------------
    ce_cnt = 0; hs_cnt = 0; hs_fall_x = -1; hs_rise_x = -1;
    dh_fall_x = -1; db_clear_x = -1; db_rise_x = -1; da_fall_x = -1;
    prev_hs = 1'b1; prev_dh = 1'b1; prev_db = 1'b1; prev_da = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (d_ls) begin
        done = 1'b1;
      end else begin
        ce_cnt += int'(d_pix_ce);
        if (d_pix_ce && !d_hsync) hs_cnt++;
        if (prev_hs && !d_hsync && hs_fall_x < 0) hs_fall_x = int'(d_x);
        if (!prev_hs && d_hsync && hs_rise_x < 0) hs_rise_x = int'(d_x);
        if (prev_dh && !y_hsync && dh_fall_x < 0) dh_fall_x = int'(y_x);
        if (prev_db && !y_blank && db_clear_x < 0) db_clear_x = int'(y_x);
        if (!prev_db && y_blank && db_rise_x < 0) db_rise_x = int'(y_x);
        if (prev_da && !y_active && da_fall_x < 0) da_fall_x = int'(y_x);
        prev_hs = d_hsync; prev_dh = y_hsync; prev_db = y_blank; prev_da = y_active;
        tick();
      end
    end
    chk("line2_found", done, 1);
    chk("line_ce_count", ce_cnt, 800);
    chk("hsync_slots", hs_cnt, 96);
    chk("hsync_fall_x", hs_fall_x, 656);
    chk("hsync_rise_x", hs_rise_x, 752);
    chk("line2_x", d_x, 0);
    chk("line2_y", d_y, 1);
    chk("line2_no_frame", d_fs, 0);
    chk("dly_hsync_fall_x", dh_fall_x, 659);
    chk("dly_blank_clear_x", db_clear_x, 3);
    chk("dly_blank_rise_x", db_rise_x, 643);
    chk("dly_active_fall_x", da_fall_x, 640);

    // ---------------- Test 6: asynchronous reset mid-line ----------------
    for (int i = 0; i < 1000 && d_x != 12'd300; i++) tick();
    chk("pre_rst_x", d_x, 300);
    chk("pre_rst_y", d_y, 1);
    #3;
    rst_d = 1'b1;
    #1;
    chk("arst_x", d_x, 0);
    chk("arst_y", d_y, 0);
    chk("arst_sync", {d_hsync, d_vsync, d_blank}, 3'b111);
    chk("arst_active", d_active, 0);
    chk("arst_pix_ce", d_pix_ce, 0);
    chk("arst_strobes", {d_ls, d_fs, d_vb}, 0);
    tick();
    tick();
    rst_d = 1'b0;
    #1;
    chk("rerel_cycle1_ce", d_pix_ce, 0);
    tick();
    chk("rerel_cycle2_ce", d_pix_ce, 1);
    tick();
    chk("rerel_x", d_x, 0);
    chk("rerel_y", d_y, 0);
    chk("rerel_active", d_active, 1);
    chk("rerel_ls", d_ls, 1);
    chk("rerel_fs", d_fs, 1);

    // ---------------- Test 3: full frame on u_tall ----------------
    rst_t = 1'b0;
    for (int i = 0; i < 10 && !t_fs; i++) tick();
    chk("tall_first_frame", t_fs, 1);
    ce_cnt = 0; vs_cnt = 0; vs_bad = 0; vb_cnt = 0; vb_x = -1; vb_y = -1;
    blank_bad = 0; act_bad = 0; max_y = 0;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (i > 0 && t_fs) begin
        done = 1'b1;
      end else begin
        ce_cnt += int'(t_pix_ce);
        if (!t_vsync) begin
          vs_cnt++;
          if (t_y != 12'd490 && t_y != 12'd491) vs_bad++;
        end
        if (t_vb) begin
          vb_cnt++; vb_x = int'(t_x); vb_y = int'(t_y);
        end
        if (t_blank !== !(t_x < 12'd8 && t_y < 12'd480)) blank_bad++;
        if (t_active === t_blank) act_bad++;
        if (int'(t_y) > max_y) max_y = int'(t_y);
        tick();
      end
    end
    chk("tall_frame_found", done, 1);
    chk("tall_frame_ce", ce_cnt, 8400);
    chk("tall_vsync_cycles", vs_cnt, 32);
    chk("tall_vsync_rows", vs_bad, 0);
    chk("tall_vblank_count", vb_cnt, 1);
    chk("tall_vblank_x", vb_x, 0);
    chk("tall_vblank_y", vb_y, 480);
    chk("tall_blank_decode", blank_bad, 0);
    chk("tall_active_vs_blank", act_bad, 0);
    chk("tall_max_y", max_y, 524);
    chk("tall_wrap_xy", {t_x, t_y}, 0);
    chk("tall_wrap_ls", t_ls, 1);

    // ---------------- Test 5: small raster, CLK_DIV=1, POL=1 ----------------
    rst_s = 1'b0;
    for (int i = 0; i < 10 && !s_fs; i++) tick();
    chk("small_first_frame", s_fs, 1);
    hs_hi = 0; vs_hi = 0; ls_cnt = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k < 40) begin
        hs_hi += int'(s_hsync);
        vs_hi += int'(s_vsync);
      end
      if (k > 0 && s_ls) ls_cnt++;
      case (k)
        0: begin
          chk("small_k0_xy", {s_x, s_y}, 0);
          chk("small_k0_ls", s_ls, 1);
          chk("small_k0_ce", s_pix_ce, 1);
          chk("small_k0_sync", {s_hsync, s_vsync, s_blank}, 3'b000);
        end
        4: chk("small_k4_hs_blank", {s_x[3:0], s_hsync, s_blank}, 6'b0100_0_1);
        5: chk("small_k5_hs", {s_x[3:0], s_hsync}, 5'b0101_1);
        6: chk("small_k6_hs", {s_x[3:0], s_hsync}, 5'b0110_1);
        7: chk("small_k7_hs", {s_x[3:0], s_hsync}, 5'b0111_0);
        8: begin
          chk("small_k8_xy", {s_x, s_y}, {12'd0, 12'd1});
          chk("small_k8_strobes", {s_ls, s_fs}, 2'b10);
        end
        24: chk("small_k24_vs", {s_y[3:0], s_vsync, s_blank}, 6'b0011_1_1);
        32: chk("small_k32_vs", {s_y[3:0], s_vsync}, 5'b0100_0);
        40: begin
          chk("small_k40_xy", {s_x, s_y}, 0);
          chk("small_k40_strobes", {s_ls, s_fs}, 2'b11);
        end
        default: ;
      endcase
      if (k < 40) tick();
    end
    chk("small_hsync_cycles", hs_hi, 10);
    chk("small_vsync_cycles", vs_hi, 8);
    chk("small_line_starts", ls_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
